// File: rtl/ha_serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial half-adder controller:
// state encodings, default operand width and the index-width helper.
package ha_serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PASS1 = 2'd1;
    localparam logic [1:0] ST_PASS2 = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Bit-index counter width; never narrower than one bit so WIDTH=1 still works.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/ha_serial_add_ctrl_ha.sv
// Single-bit half adder, purely combinational. Time-shared by the serial
// adder controller for both passes of every bit.
module ha_serial_add_ctrl_ha (
    input  logic A,
    input  logic B,
    output logic Cout,
    output logic Sum
);

    // Half-adder equations
    always_comb begin
        Sum  = A ^ B;
        Cout = A & B;
    end

endmodule

// File: rtl/ha_serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder built from one time-shared half adder.
// Each bit takes two passes: a[i]+b[i], then partial sum + running carry.
// Build option: define ADDER_SAT_EN to saturate sum to all ones when the
// final carry is set (cout still reports the true carry).
module ha_serial_add_ctrl
    import ha_serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int IDXW = idx_width(WIDTH);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             p_q, p_d;
    logic             g_q, g_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic ha_a, ha_b, ha_sum, ha_cout;

    ha_serial_add_ctrl_ha u_ha (
        .A    (ha_a),
        .B    (ha_b),
        .Cout (ha_cout),
        .Sum  (ha_sum)
    );

    // HA input mux: operand bits in PASS1, partial sum and carry in PASS2, idle otherwise
    always_comb begin
        ha_a = 1'b0;
        ha_b = 1'b0;
        case (state_q)
            ST_PASS1: begin
                ha_a = opa_q[idx_q];
                ha_b = opb_q[idx_q];
            end
            ST_PASS2: begin
                ha_a = p_q;
                ha_b = carry_q;
            end
            default: begin
                ha_a = 1'b0;
                ha_b = 1'b0;
            end
        endcase
    end

    // Sequencer next-state and datapath update
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        p_d     = p_q;
        g_d     = g_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_PASS1;
                    opa_d   = a;
                    opb_d   = b;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    res_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PASS1: begin
                p_d     = ha_sum;
                g_d     = ha_cout;
                state_d = ST_PASS2;
            end
            ST_PASS2: begin
                res_d[idx_q] = ha_sum;
                // g and the second-pass carry are mutually exclusive, so OR is exact
                carry_d = g_q | ha_cout;
                if (idx_q != LAST_IDX) begin
                    idx_d   = idx_q + IDXW'(1);
                    state_d = ST_PASS1;
                end else begin
                    state_d = ST_DONE;
                    cout_d  = carry_d;
`ifdef ADDER_SAT_EN
                    sum_d   = carry_d ? {WIDTH{1'b1}} : res_d;
`else
                    sum_d   = res_d;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            p_q     <= 1'b0;
            g_q     <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            p_q     <= p_d;
            g_q     <= g_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Status and result outputs decoded from registered state
    always_comb begin
        busy = (state_q == ST_PASS1) || (state_q == ST_PASS2);
        done = (state_q == ST_DONE);
        sum  = sum_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_ha_serial_add_ctrl.sv
// Self-checking bench for ha_serial_add_ctrl (WIDTH=8). Expected results are
// queued when a start is accepted and compared when done pulses.
module tb_ha_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_vec = 0;
    int n_err = 0;

    logic [W:0] exp_q[$];

    ha_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: {cout, sum}
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] full;
        full = {1'b0, x} + {1'b0, y};
`ifdef ADDER_SAT_EN
        if (full[W]) full[W-1:0] = {W{1'b1}};
`endif
        return full;
    endfunction

    // Scoreboard: compare each done pulse against the oldest queued result
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                chk("sum", 32'(sum), 32'(e[W-1:0]));
                chk("cout", 32'(cout), 32'(e[W]));
                $display("txn: sum=%02h cout=%0d expected sum=%02h cout=%0d", sum, cout, e[W-1:0], e[W]);
            end
        end
    end

    // Drive one accepted request; returns at the negedge after the accepting edge
    task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        a = x;
        b = y;
        exp_q.push_back(model(x, y));
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // Wait (bounded) for done, counting busy cycles and cycles waited
    task automatic wait_done(input string tag, output int n_busy, output int n_cyc);
        n_busy = 0;
        n_cyc = 0;
        while (done !== 1'b1 && n_cyc < 200) begin
            if (busy === 1'b1) n_busy++;
            n_cyc++;
            @(negedge clk);
        end
        if (done !== 1'b1) chk({tag, "_timeout"}, 32'(done), 32'(1));
    endtask

    initial begin
        int nb, nc;
        bit saw;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_sum", 32'(sum), 32'(0));
        chk("rst_cout", 32'(cout), 32'(0));
        rst = 1'b0;

        // Zero operands: latency and busy duration
        do_start(8'h00, 8'h00);
        wait_done("zero", nb, nc);
        chk("zero_latency", 32'(nc), 32'(2 * W));
        chk("zero_busy_cycles", 32'(nb), 32'(2 * W));
        chk("done_busy_low", 32'(busy), 32'(0));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'(0));

        do_start(8'hA5, 8'h5A);
        wait_done("a5_5a", nb, nc);
        do_start(8'hFF, 8'h01);
        wait_done("ff_01", nb, nc);

        // Start while busy is ignored
        do_start(8'h0F, 8'h01);
        repeat (4) @(negedge clk);
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", nb, nc);
        @(negedge clk);
        chk("ignore_queue_empty", 32'(exp_q.size()), 32'(0));

        // Reset abort at edge 7
        do_start(8'h80, 8'h80);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_sum", 32'(sum), 32'(0));
        chk("abort_cout", 32'(cout), 32'(0));
        rst = 1'b0;
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) saw = 1'b1;
        end
        chk("abort_no_done", 32'(saw), 32'(0));
        do_start(8'h03, 8'h04);
        wait_done("after_abort", nb, nc);

        // Back-to-back with start held high through DONE
        @(negedge clk);
        start = 1'b1;
        a = 8'h01;
        b = 8'h02;
        exp_q.push_back(model(8'h01, 8'h02));
        @(negedge clk);
        a = 8'h7F;
        b = 8'h01;
        exp_q.push_back(model(8'h7F, 8'h01));
        wait_done("b2b_first", nb, nc);
        chk("b2b_first_busy_low", 32'(busy), 32'(0));
        @(negedge clk);
        start = 1'b0;
        chk("b2b_reaccept_busy", 32'(busy), 32'(1));
        wait_done("b2b_second", nb, nc);
        chk("b2b_spacing", 32'(nc + 1), 32'(2 * W + 1));
        chk("b2b_busy_cycles", 32'(nb), 32'(2 * W));
        chk("b2b_second_busy_low", 32'(busy), 32'(0));

        // Random operand pairs
        for (int k = 0; k < 200; k++) begin
            do_start(W'($urandom), W'($urandom));
            wait_done("random", nb, nc);
        end
        repeat (3) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
